// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the hazard / pipeline-control unit of the 5-stage
// MIPS core: forward-select encoding, stage index constants, the packed
// stage-control ordering {WB,MEM,EXE,ID,IF} and the select-width helper.
package hazard_pkg;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // Bit positions inside a stage_en / stage_rst vector.
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Per-stage control bits; declared MSB first so that fetch lands in bit 0.
    typedef struct packed {
        logic wb;
        logic mem;
        logic exe;
        logic id;
        logic fetch;
    } stage_ctrl_t;

    // Width of a forward select: register file plus one code per stage.
    function automatic int sel_width(input int fwd_stages);
        return (fwd_stages < 1) ? 1 : $clog2(fwd_stages + 1);
    endfunction

endpackage

// File: rtl/muldiv_scoreboard.sv
// muldiv_scoreboard
// Tracks the single multi-cycle MUL/DIV unit: remaining busy cycles (cnt)
// and its destination register (pend_addr).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   issue             a MUL/DIV leaves ID this cycle
//   hold              pipeline frozen by the debug controller
//   rs_*/rt_*         ID source operands and their use flags
//   wb_wen, wb_addr   ID destination (also captured as pend_addr at issue)
//   is_muldiv         ID instruction is a MUL/DIV
//   busy, done        unit occupied / writes back this cycle
//   raw_hazard, waw_hazard, struct_hazard   conflicts with the ID instruction
module muldiv_scoreboard
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    input  logic       hold,
    input  logic [4:0] rs_addr,
    input  logic       rs_used,
    input  logic [4:0] rt_addr,
    input  logic       rt_used,
    input  logic       wb_wen,
    input  logic [4:0] wb_addr,
    input  logic       is_muldiv,
    output logic       busy,
    output logic       done,
    output logic       raw_hazard,
    output logic       waw_hazard,
    output logic       struct_hazard
);

    localparam int CNT_BITS = $clog2(MULDIV_LAT + 1);

    logic [CNT_BITS-1:0] cnt;
    logic [4:0]          pend_addr;
    logic                occupied;
    logic                pend_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pend_addr <= '0;
        end else if (!hold) begin
            if (issue) begin
                cnt       <= CNT_BITS'(MULDIV_LAT);
                pend_addr <= wb_addr;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_BITS'(1);
            end
        end
    end

    assign occupied   = (cnt != '0);
    assign pend_valid = occupied && (pend_addr != 5'd0);

    // A reset cycle already counts as aborted, so status drops immediately.
    assign busy = occupied && !rst;
    assign done = (cnt == CNT_BITS'(1)) && !hold && !rst;

    assign struct_hazard = occupied && is_muldiv;
    assign raw_hazard    = pend_valid && ((rs_used && rs_addr == pend_addr) ||
                                          (rt_used && rt_addr == pend_addr));
    assign waw_hazard    = pend_valid && wb_wen && (wb_addr == pend_addr);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard and pipeline-control unit sitting beside the ID decoder: N-stage
// operand forwarding, load-use stalls, predict-not-taken branch flush,
// MUL/DIV scoreboarding, debug single-step and a saturating stall counter.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   debug_en, debug_step        debug hold and single-step request
//   id_*                        operands / destination of the ID instruction
//   stg_wen/waddr/is_load       downstream stage results (stage 0 = EXE, LSBs)
//   branch_taken_exe            branch in EXE resolved taken
//   fwd_a_sel, fwd_b_sel        0 = register file, k+1 = stage k result
//   stage_en, stage_rst         per-stage enables/resets {WB,MEM,EXE,ID,IF}
//   muldiv_busy, muldiv_done    MUL/DIV status
//   stall_cycles                saturating count of hazard-stall cycles
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int LOAD_READY = 1,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            debug_en,
    input  logic                            debug_step,
    input  logic [4:0]                      id_rs_addr,
    input  logic [4:0]                      id_rt_addr,
    input  logic                            id_rs_used,
    input  logic                            id_rt_used,
    input  logic                            id_wb_wen,
    input  logic [4:0]                      id_wb_addr,
    input  logic                            id_is_muldiv,
    input  logic [FWD_STAGES-1:0]           stg_wen,
    input  logic [5*FWD_STAGES-1:0]         stg_waddr,
    input  logic [FWD_STAGES-1:0]           stg_is_load,
    input  logic                            branch_taken_exe,
    output logic [$clog2(FWD_STAGES+1)-1:0] fwd_a_sel,
    output logic [$clog2(FWD_STAGES+1)-1:0] fwd_b_sel,
    output logic [4:0]                      stage_en,
    output logic [4:0]                      stage_rst,
    output logic                            muldiv_busy,
    output logic                            muldiv_done,
    output logic [CNT_W-1:0]                stall_cycles
);

    localparam int SEL_W = sel_width(FWD_STAGES);

    typedef struct packed {
        logic             load_hz;
        logic [SEL_W-1:0] sel;
    } fwd_t;

    // Youngest (lowest-index) matching producer wins; a load that has not yet
    // reached LOAD_READY cannot forward and requests a stall instead.
    function automatic fwd_t fwd_lookup(input logic [4:0] addr, input logic used);
        fwd_t r;
        logic found;
        r     = '{load_hz: 1'b0, sel: SEL_W'(FWD_RF)};
        found = 1'b0;
        if (used && addr != 5'd0) begin
            for (int k = 0; k < FWD_STAGES; k++) begin
                if (!found && stg_wen[k] && stg_waddr[5*k +: 5] == addr) begin
                    found = 1'b1;
                    if (stg_is_load[k] && k < LOAD_READY) r.load_hz = 1'b1;
                    else                                  r.sel     = SEL_W'(k + 1);
                end
            end
        end
        return r;
    endfunction

    fwd_t        fwd_a, fwd_b;
    logic        step_q, step_rise, hold;
    logic        load_stall, muldiv_stall, hazard_stall, issue, stall_active;
    logic        raw_hazard, waw_hazard, struct_hazard;
    stage_ctrl_t en_c, rst_c;

    assign fwd_a = fwd_lookup(id_rs_addr, id_rs_used);
    assign fwd_b = fwd_lookup(id_rt_addr, id_rt_used);

    assign fwd_a_sel = rst ? '0 : fwd_a.sel;
    assign fwd_b_sel = rst ? '0 : fwd_b.sel;

    // Step edge detector: a rising edge of debug_step releases one cycle.
    always_ff @(posedge clk) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= debug_step;
    end

    assign step_rise = debug_step && !step_q;
    assign hold      = debug_en && !step_rise;

    assign load_stall   = fwd_a.load_hz || fwd_b.load_hz;
    assign muldiv_stall = raw_hazard || waw_hazard || struct_hazard;
    assign hazard_stall = load_stall || muldiv_stall;

    // A taken branch kills the ID instruction, so it can neither stall nor issue.
    assign issue        = id_is_muldiv && !hazard_stall && !branch_taken_exe && !hold && !rst;
    assign stall_active = hazard_stall && !branch_taken_exe && !hold && !rst;

    muldiv_scoreboard #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .issue         (issue),
        .hold          (hold),
        .rs_addr       (id_rs_addr),
        .rs_used       (id_rs_used),
        .rt_addr       (id_rt_addr),
        .rt_used       (id_rt_used),
        .wb_wen        (id_wb_wen),
        .wb_addr       (id_wb_addr),
        .is_muldiv     (id_is_muldiv),
        .busy          (muldiv_busy),
        .done          (muldiv_done),
        .raw_hazard    (raw_hazard),
        .waw_hazard    (waw_hazard),
        .struct_hazard (struct_hazard)
    );

    // NOTE: every always_comb output gets a full default first, so no path
    // through the priority chain can leave a value unassigned (no latch).
    always_comb begin
        en_c  = '1;
        rst_c = '0;
        if (rst) begin
            rst_c = '1;
        end else if (hold) begin
            en_c = '0;
        end else if (branch_taken_exe) begin
            rst_c.fetch = 1'b1;
            rst_c.id    = 1'b1;
        end else if (hazard_stall) begin
            en_c.fetch = 1'b0;
            en_c.id    = 1'b0;
            rst_c.exe  = 1'b1;
        end
    end

    assign stage_en  = en_c;
    assign stage_rst = rst_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_active && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
// Self-checking bench for hazard_unit: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of the forwarding / stall / scoreboard rules.
module tb_hazard_unit;

    localparam int FS  = 2;
    localparam int LR  = 1;
    localparam int LAT = 4;
    localparam int CW  = 4;
    localparam int SW  = $clog2(FS + 1);

    logic            clk = 1'b0;
    logic            rst, debug_en, debug_step;
    logic [4:0]      id_rs_addr, id_rt_addr, id_wb_addr;
    logic            id_rs_used, id_rt_used, id_wb_wen, id_is_muldiv;
    logic [FS-1:0]   stg_wen, stg_is_load;
    logic [5*FS-1:0] stg_waddr;
    logic            branch_taken_exe;
    logic [SW-1:0]   fwd_a_sel, fwd_b_sel;
    logic [4:0]      stage_en, stage_rst;
    logic            muldiv_busy, muldiv_done;
    logic [CW-1:0]   stall_cycles;

    always #5 clk = ~clk;

    hazard_unit #(
        .FWD_STAGES (FS),
        .LOAD_READY (LR),
        .MULDIV_LAT (LAT),
        .CNT_W      (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .debug_en         (debug_en),
        .debug_step       (debug_step),
        .id_rs_addr       (id_rs_addr),
        .id_rt_addr       (id_rt_addr),
        .id_rs_used       (id_rs_used),
        .id_rt_used       (id_rt_used),
        .id_wb_wen        (id_wb_wen),
        .id_wb_addr       (id_wb_addr),
        .id_is_muldiv     (id_is_muldiv),
        .stg_wen          (stg_wen),
        .stg_waddr        (stg_waddr),
        .stg_is_load      (stg_is_load),
        .branch_taken_exe (branch_taken_exe),
        .fwd_a_sel        (fwd_a_sel),
        .fwd_b_sel        (fwd_b_sel),
        .stage_en         (stage_en),
        .stage_rst        (stage_rst),
        .muldiv_busy      (muldiv_busy),
        .muldiv_done      (muldiv_done),
        .stall_cycles     (stall_cycles)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_busy_left = 0;   // un-held cycles the MUL/DIV still occupies
    int m_pend      = 0;   // destination of the in-flight MUL/DIV
    bit m_step_prev = 0;   // debug_step as seen on the previous cycle
    int m_stalls    = 0;   // stall cycles so far

    function automatic void fwd_ref(input int addr, input bit used, output int sel, output bit lhz);
        sel = 0;
        lhz = 0;
        if (!used || addr == 0) return;
        for (int k = 0; k < FS; k++) begin
            if (stg_wen[k] && stg_waddr[5*k +: 5] == addr) begin
                if (stg_is_load[k] && k < LR) lhz = 1;
                else                          sel = k + 1;
                return;
            end
        end
    endfunction

    always @(negedge clk) begin : compare
        int  sa, sb, e_en, e_rst;
        bit  la, lb, held, busy, mstall, stall, issue;
        fwd_ref(id_rs_addr, id_rs_used, sa, la);
        fwd_ref(id_rt_addr, id_rt_used, sb, lb);
        held   = debug_en && !(debug_step && !m_step_prev);
        busy   = m_busy_left > 0;
        mstall = busy && (id_is_muldiv ||
                 (m_pend != 0 && ((id_rs_used && id_rs_addr == m_pend) ||
                                  (id_rt_used && id_rt_addr == m_pend) ||
                                  (id_wb_wen  && id_wb_addr == m_pend))));
        stall  = la || lb || mstall;
        e_en   = 'h1F;
        e_rst  = 0;
        if (rst)                   e_rst = 'h1F;
        else if (held)             e_en  = 0;
        else if (branch_taken_exe) e_rst = 'b00011;
        else if (stall) begin
            e_en  = 'b11100;
            e_rst = 'b00100;
        end
        check("fwd_a_sel",    fwd_a_sel,    rst ? 0 : sa);
        check("fwd_b_sel",    fwd_b_sel,    rst ? 0 : sb);
        check("stage_en",     stage_en,     e_en);
        check("stage_rst",    stage_rst,    e_rst);
        check("muldiv_busy",  muldiv_busy,  int'(busy && !rst));
        check("muldiv_done",  muldiv_done,  int'(m_busy_left == 1 && !held && !rst));
        check("stall_cycles", stall_cycles, m_stalls);
        // Advance the model to what the next clock edge produces.
        issue = id_is_muldiv && !stall && !branch_taken_exe && !held && !rst;
        if (rst) begin
            m_busy_left = 0;
            m_pend      = 0;
            m_step_prev = 0;
            m_stalls    = 0;
        end else begin
            m_step_prev = debug_step;
            if (!held) begin
                if (issue) begin
                    m_busy_left = LAT;
                    m_pend      = id_wb_addr;
                end else if (m_busy_left > 0) begin
                    m_busy_left--;
                end
                if (stall && !branch_taken_exe)
                    m_stalls = (m_stalls + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_stalls + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        debug_en = 0; debug_step = 0; branch_taken_exe = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_wb_addr = 0;
        id_rs_used = 0; id_rt_used = 0; id_wb_wen = 0; id_is_muldiv = 0;
        stg_wen = '0; stg_waddr = '0; stg_is_load = '0;
    endtask

    task automatic set_stg(input int k, input bit wen, input int addr, input bit load);
        stg_wen[k]          = wen;
        stg_waddr[5*k +: 5] = 5'(addr);
        stg_is_load[k]      = load;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    task automatic issue_mul(input int dest);
        idle();
        id_is_muldiv = 1; id_wb_wen = 1; id_wb_addr = 5'(dest);
        next_cycle();
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1;

        // Reset state.
        next_cycle(); #1;
        check("rst stage_rst", stage_rst, 'h1F);
        check("rst busy", muldiv_busy, 0);
        check("rst fwd_a", fwd_a_sel, 0);
        next_cycle(); rst = 0; #1;
        check("post-rst stall_cycles", stall_cycles, 0);
        check("post-rst stage_en", stage_en, 'h1F);
        check("post-rst stage_rst", stage_rst, 0);

        // ALU result forwarding from EXE, then MEM; r0 never forwards.
        next_cycle(); idle();
        set_stg(0, 1, 5, 0);
        id_rs_addr = 5; id_rt_addr = 5; id_rs_used = 1; id_rt_used = 1; #1;
        check("exe fwd_a", fwd_a_sel, 1);
        check("exe fwd_b", fwd_b_sel, 1);
        check("exe no stall", stage_en, 'h1F);
        set_stg(0, 0, 0, 0); set_stg(1, 1, 5, 0); #1;
        check("mem fwd_a", fwd_a_sel, 2);
        check("mem fwd_b", fwd_b_sel, 2);
        set_stg(0, 1, 5, 0); #1;
        check("youngest wins", fwd_a_sel, 1);
        set_stg(0, 1, 0, 0); id_rs_addr = 0; #1;
        check("r0 not forwarded", fwd_a_sel, 0);

        // Load-use: one bubble, then forward from MEM.
        do_reset();
        set_stg(0, 1, 3, 1); id_rt_addr = 3; id_rt_used = 1; #1;
        check("load stall en", stage_en, 'b11100);
        check("load stall rst", stage_rst, 'b00100);
        check("load stall sel", fwd_b_sel, 0);
        next_cycle(); idle();
        set_stg(1, 1, 3, 1); id_rt_addr = 3; id_rt_used = 1; #1;
        check("load fwd mem", fwd_b_sel, 2);
        check("load stall count", stall_cycles, 1);
        check("load resumed", stage_en, 'h1F);

        // MUL to r8 followed by a reader of r8.
        do_reset();
        id_is_muldiv = 1; id_wb_wen = 1; id_wb_addr = 8; #1;
        check("mul issue busy", muldiv_busy, 0);
        check("mul issue en", stage_en, 'h1F);
        next_cycle(); idle();
        id_rs_addr = 8; id_rs_used = 1;
        for (int i = 1; i <= LAT; i++) begin
            #1;
            check("mul busy", muldiv_busy, 1);
            check("mul done", muldiv_done, int'(i == LAT));
            check("mul raw stall", stage_en, 'b11100);
            next_cycle();
        end
        #1;
        check("mul released busy", muldiv_busy, 0);
        check("mul released en", stage_en, 'h1F);
        check("mul stall count", stall_cycles, LAT);

        // Branch during a load stall, with a MUL in ID that must not issue.
        do_reset();
        set_stg(0, 1, 3, 1); id_rt_addr = 3; id_rt_used = 1;
        branch_taken_exe = 1; id_is_muldiv = 1; #1;
        check("branch rst", stage_rst, 'b00011);
        check("branch en", stage_en, 'h1F);
        next_cycle(); idle(); #1;
        check("branch stall count", stall_cycles, 0);
        check("branch killed mul", muldiv_busy, 0);

        // Debug hold with cnt=3, then a single step.
        do_reset();
        issue_mul(9);
        next_cycle();
        debug_en = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("dbg hold en", stage_en, 0);
            check("dbg hold busy", muldiv_busy, 1);
            check("dbg hold done", muldiv_done, 0);
            next_cycle();
        end
        debug_step = 1; #1;
        check("dbg step en", stage_en, 'h1F);
        next_cycle(); #1;
        check("dbg step level held", stage_en, 0);
        next_cycle(); debug_en = 0; debug_step = 0; #1;
        check("dbg cnt2 done", muldiv_done, 0);
        next_cycle(); #1;
        check("dbg cnt1 done", muldiv_done, 1);
        next_cycle(); #1;
        check("dbg finished", muldiv_busy, 0);

        // Reset at cnt=2 aborts the MUL without a done pulse.
        do_reset();
        issue_mul(10);
        next_cycle(); next_cycle(); #1;
        check("pre-abort busy", muldiv_busy, 1);
        rst = 1; #1;
        check("abort busy", muldiv_busy, 0);
        check("abort done", muldiv_done, 0);
        check("abort stage_rst", stage_rst, 'h1F);
        next_cycle(); #1;
        check("abort stage_rst held", stage_rst, 'h1F);
        next_cycle(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("abort no busy", muldiv_busy, 0);
            check("abort no done", muldiv_done, 0);
            next_cycle();
        end

        // Counter saturation.
        do_reset();
        set_stg(0, 1, 3, 1); id_rs_addr = 3; id_rs_used = 1;
        for (int i = 0; i < 20; i++) next_cycle();
        #1;
        check("stall saturate", stall_cycles, (1 << CW) - 1);

        // Randomized traffic, checked by the model every cycle.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            rst              = ($urandom_range(0, 149) == 0);
            debug_en         = ($urandom_range(0, 7) == 0);
            debug_step       = 1'($urandom_range(0, 1));
            branch_taken_exe = ($urandom_range(0, 9) == 0);
            id_rs_addr       = 5'($urandom_range(0, 3));
            id_rt_addr       = 5'($urandom_range(0, 3));
            id_wb_addr       = 5'($urandom_range(0, 3));
            id_rs_used       = 1'($urandom_range(0, 1));
            id_rt_used       = 1'($urandom_range(0, 1));
            id_wb_wen        = 1'($urandom_range(0, 1));
            id_is_muldiv     = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < FS; k++)
                set_stg(k, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                        $urandom_range(0, 3) == 0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
